// File: rtl/gbc_mem_pkg.sv
// Shared constants for the GBC memory system: requester IDs and BRAM port widths.
package gbc_mem_pkg;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned BRAM_DATA_W = 8;
  localparam int unsigned BRAM_ADDR_W = 16;

  localparam logic [BRAM_ADDR_W-1:0] DEFAULT_OFFSET_MASK = 16'h00FF;

endpackage

// File: rtl/gbc_bram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant generator with last-grant register.
// prio_b_i forces B to win a tie regardless of the last grant.
module rr_arb2
  import gbc_mem_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic prio_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_a_o    = 1'b0;
    gnt_b_o    = 1'b0;
    last_gnt_d = last_gnt_q;
    if (!reset_i) begin
      if (req_a_i && req_b_i) begin
        if (prio_b_i || (last_gnt_q == REQ_A)) gnt_b_o = 1'b1;
        else                                   gnt_a_o = 1'b1;
      end else begin
        gnt_a_o = req_a_i;
        gnt_b_o = req_b_i;
      end
    end
    if (gnt_a_o)      last_gnt_d = REQ_A;
    else if (gnt_b_o) last_gnt_d = REQ_B;
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) last_gnt_q <= REQ_B;
    else         last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/gbc_bram_arbiter.sv
// Two-requester arbiter for one single-port BRAM with tagged read-data return.
// Optional B burst lock with starvation limit: define GBC_BRAM_ARB_LOCK_EN.
module gbc_bram_arbiter
  import gbc_mem_pkg::*;
#(
  parameter logic [BRAM_ADDR_W-1:0] P_OFFSET_MASK = DEFAULT_OFFSET_MASK,
  parameter int unsigned            P_MAX_BURST   = 4
) (
  input  logic                   I_CLK,
  input  logic                   I_RESET,
  input  logic                   I_A_REQ,
  input  logic                   I_A_WE,
  input  logic [BRAM_ADDR_W-1:0] I_A_ADDR,
  input  logic [BRAM_DATA_W-1:0] I_A_WDATA,
  output logic                   O_A_GNT,
  output logic                   O_A_RVALID,
  output logic [BRAM_DATA_W-1:0] O_A_RDATA,
  input  logic                   I_B_REQ,
  input  logic                   I_B_WE,
  input  logic [BRAM_ADDR_W-1:0] I_B_ADDR,
  input  logic [BRAM_DATA_W-1:0] I_B_WDATA,
  output logic                   O_B_GNT,
  output logic                   O_B_RVALID,
  output logic [BRAM_DATA_W-1:0] O_B_RDATA,
`ifdef GBC_BRAM_ARB_LOCK_EN
  input  logic                   I_B_LOCK,
`endif
  output logic                   O_BRAM_EN,
  output logic                   O_BRAM_WE,
  output logic [BRAM_ADDR_W-1:0] O_BRAM_ADDR,
  output logic [BRAM_DATA_W-1:0] O_BRAM_DIN,
  input  logic [BRAM_DATA_W-1:0] I_BRAM_DOUT
);

  logic       a_gnt, b_gnt;
  logic       prio_b;
  logic [1:0] rd_tag_q, rd_tag_d;

`ifdef GBC_BRAM_ARB_LOCK_EN
  logic       lock_q, lock_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  // Lock holds B's tie priority only until the burst budget is spent.
  assign prio_b = lock_q && (burst_cnt_q < 4'(P_MAX_BURST));

  always_comb begin
    lock_d      = lock_q;
    burst_cnt_d = burst_cnt_q;
    if (a_gnt) begin
      lock_d      = 1'b0;
      burst_cnt_d = 4'd0;
    end else if (b_gnt) begin
      if (!I_B_LOCK) begin
        lock_d      = 1'b0;
        burst_cnt_d = 4'd0;
      end else begin
        lock_d = 1'b1;
        if (I_A_REQ && (burst_cnt_q < 4'(P_MAX_BURST)))
          burst_cnt_d = burst_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      lock_q      <= 1'b0;
      burst_cnt_q <= 4'd0;
    end else begin
      lock_q      <= lock_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign prio_b = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .clk_i    (I_CLK),
    .reset_i  (I_RESET),
    .req_a_i  (I_A_REQ),
    .req_b_i  (I_B_REQ),
    .prio_b_i (prio_b),
    .gnt_a_o  (a_gnt),
    .gnt_b_o  (b_gnt)
  );

  assign O_A_GNT = a_gnt;
  assign O_B_GNT = b_gnt;

  always_comb begin
    O_BRAM_EN   = 1'b0;
    O_BRAM_WE   = 1'b0;
    O_BRAM_ADDR = '0;
    O_BRAM_DIN  = '0;
    if (a_gnt) begin
      O_BRAM_EN   = 1'b1;
      O_BRAM_WE   = I_A_WE;
      O_BRAM_ADDR = I_A_ADDR & P_OFFSET_MASK;
      O_BRAM_DIN  = I_A_WDATA;
    end else if (b_gnt) begin
      O_BRAM_EN   = 1'b1;
      O_BRAM_WE   = I_B_WE;
      O_BRAM_ADDR = I_B_ADDR & P_OFFSET_MASK;
      O_BRAM_DIN  = I_B_WDATA;
    end
  end

  assign rd_tag_d = {b_gnt & ~I_B_WE, a_gnt & ~I_A_WE};

  always_ff @(posedge I_CLK) begin
    if (I_RESET) rd_tag_q <= 2'b00;
    else         rd_tag_q <= rd_tag_d;
  end

  // Masking with I_RESET kills a read return that lands in a reset cycle.
  assign O_A_RVALID = rd_tag_q[0] & ~I_RESET;
  assign O_B_RVALID = rd_tag_q[1] & ~I_RESET;
  assign O_A_RDATA  = O_A_RVALID ? I_BRAM_DOUT : '0;
  assign O_B_RDATA  = O_B_RVALID ? I_BRAM_DOUT : '0;

endmodule
